// File: rtl/mod_add_pipe_if.sv
// mod_add_pipe_if: stream bundle for the pipelined modular adder.
//
// Handshake rule for both directions: a transfer happens on a rising clock
// edge where the producer's valid and the consumer's ready are both 1. A
// producer holding valid=1 keeps its data stable until that transfer.
//
// Input side : valid_i, ready_o, a_i, b_i, q_i
// Output side: valid_o, ready_i, c_o, err_o
//
// Modports:
//   slave  - the adder (consumes operands, produces results)
//   master - the environment (produces operands, consumes results)
interface mod_add_pipe_if #(
  parameter int QW = 23,
  parameter int AW = 24
);
  logic          valid_i;
  logic          ready_o;
  logic [AW-1:0] a_i;
  logic [AW-1:0] b_i;
  logic [QW-1:0] q_i;
  logic          valid_o;
  logic          ready_i;
  logic [QW-1:0] c_o;
  logic          err_o;

  modport slave (
    input  valid_i, a_i, b_i, q_i, ready_i,
    output ready_o, valid_o, c_o, err_o
  );

  modport master (
    output valid_i, a_i, b_i, q_i, ready_i,
    input  ready_o, valid_o, c_o, err_o
  );
endinterface

// File: rtl/mod_add_pipe.sv
// mod_add_pipe: two-stage pipelined modular adder, c = (a + b) mod q.
// Sum leg of the NTT butterfly datapath.
//
// Ports:
//   clk_i  - clock, rising-edge
//   rst_i  - synchronous active-high reset
//   bus    - mod_add_pipe_if.slave: operand stream in (valid_i/ready_o,
//            a_i, b_i, q_i) and result stream out (valid_o/ready_i, c_o,
//            err_o). err_o flags a result whose a or b was >= its q.
//
// Stage 1 registers the widened sum, the modulus and the range flag.
// Stage 2 does a single conditional subtraction of q. Both stages advance
// together whenever the output register is empty or being drained, so the
// whole pipe stalls as one and ready_o is that advance condition.
// AW must equal QW+1.
module mod_add_pipe #(
  parameter int QW = 23,
  parameter int AW = 24
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mod_add_pipe_if.slave  bus
);

  logic          adv;
  logic          v1;
  logic [AW:0]   s1;
  logic [QW-1:0] q1;
  logic          e1;
  logic          v2;
  logic [QW-1:0] c_q;
  logic          err_q;
  logic [AW+1:0] d;
  logic [AW-1:0] q_ext;
  logic          unused_d_hi;

  assign adv = ~v2 | bus.ready_i;

  assign bus.ready_o = adv;
  assign bus.valid_o = v2;
  assign bus.c_o     = c_q;
  assign bus.err_o   = err_q;

  assign q_ext = {{(AW-QW){1'b0}}, bus.q_i};

  // Signed difference s1 - q1 with one extra bit so the MSB is the sign.
  assign d = {1'b0, s1} - {{(AW+2-QW){1'b0}}, q1};

  // Only the sign and the low QW bits of d feed the result.
  assign unused_d_hi = ^d[AW:QW];

  // Stage 1: capture operands. Data registers update on bubbles too; v1
  // marks whether they carry a real transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1 <= 1'b0;
      s1 <= '0;
      q1 <= '0;
      e1 <= 1'b0;
    end else if (adv) begin
      v1 <= bus.valid_i;
      s1 <= {1'b0, bus.a_i} + {1'b0, bus.b_i};
      q1 <= bus.q_i;
      e1 <= (bus.a_i >= q_ext) | (bus.b_i >= q_ext);
    end
  end

  // Stage 2: one conditional subtraction. For in-range operands the sum
  // is below 2q, so a single subtraction fully reduces it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v2    <= 1'b0;
      c_q   <= '0;
      err_q <= 1'b0;
    end else if (adv) begin
      v2    <= v1;
      c_q   <= d[AW+1] ? s1[QW-1:0] : d[QW-1:0];
      err_q <= e1;
    end
  end

endmodule

// File: doc/mod_add_pipe.md
Name: mod_add_pipe

Overview:
- Pipelined modular adder: c = (a + b) mod q. It is the additive counterpart of the existing combinational modular subtractor and forms the sum leg of the NTT butterfly datapath.
- Streams operand pairs through a 2-stage pipeline with valid/ready flow control, so it can sit between butterfly operand fetch and the result write-back buffer.
- Flags operands that are out of range.

Parameters:
- QW, 23, width of modulus q and of result c.
- AW, 24, width of operands a and b (AW = QW+1 is required).

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- valid_i  input  1  operand pair on a_i/b_i/q_i is valid
- ready_o  output  1  block accepts an operand pair this cycle
- a_i  input  AW  operand a
- b_i  input  AW  operand b
- q_i  input  QW  modulus, sampled together with the operands
- valid_o  output  1  c_o/err_o hold a valid result
- ready_i  input  1  downstream accepts the result
- c_o  output  QW  (a+b) mod q
- err_o  output  1  range error: operand a or b was >= q for this result

Behaviour:
- Reset (rst_i=1 at clock edge):
  - Both stage-valid bits cleared.
  - valid_o=0, c_o=0, err_o=0; all internal data registers cleared.
  - Reset has priority over any transfer in that cycle.
  - In-flight results are discarded and never appear on the outputs.
- Transfers:
  - Input transfer when valid_i & ready_o.
  - Output transfer when valid_o & ready_i.
- Advance enable: adv = ~valid_o | ready_i.
  - ready_o = adv, driven combinationally.
  - When adv=0, all pipeline registers hold their values, and c_o/err_o are stable while valid_o=1.
  - Output data must not change before the handshake completes.
- Stage 1, on adv:
  - v1 <= valid_i.
  - s1 <= zero-extended a_i + b_i at AW+1 bits, so there is no overflow.
  - q1 <= q_i.
  - e1 <= (a_i >= q_i) | (b_i >= q_i).
- Stage 2, on adv:
  - v2 <= v1.
  - d = s1 - q1, computed at AW+2 bits, signed.
  - c_o <= (d >= 0) ? d[QW-1:0] : s1[QW-1:0].
  - err_o <= e1.
  - valid_o = v2.
- Latency: 2 cycles from the input transfer to valid_o, with no stall. Throughput is 1 result per cycle while ready_i=1.
- Arithmetic contract:
  - c_o is correct when a, b < q and 2 <= q < 2^QW.
  - For err_o=1 results, c_o is the single-subtraction value computed above. It is not fully reduced, and that is accepted.
  - q=0 or q=1 is outside the contract, with no required c_o. The logic must not hang.
- Bubbles: valid_i=0 cycles with adv=1 insert bubbles. Bubbles propagate as valid_o=0. Data registers may update during a bubble, but valid_o gates them.
- Full-stall boundary: with v1=v2=1 and ready_i=0:
  - ready_o=0.
  - Upstream must hold its operands, and the held operands are not captured.
  - When ready_i rises, the result transfers and the next input is accepted in the same cycle.
- Ordering: results leave in strict input order. No reordering or dropping except on reset.
- Boundary sums:
  - a+b == q gives 0.
  - a+b == 2q-2 (max in-range sum) gives q-2.
  - a+b < q passes through unchanged.
- q may change on every transaction. Each result uses the q sampled with its own operands.

Test Plan:
1. q=40. Send (a=20,b=13), then (a=7,b=13) back-to-back with ready_i=1. Expected: valid_o on cycles 2 and 3 after the first accept, with c_o=33 then c_o=20, err_o=0.
2. q=40, (a=30,b=25) gives 15. q=8380417, (a=8380416,b=8380416) gives 8380415. (a=20,b=20,q=40) gives 0. All with err_o=0.
3. Backpressure: stream 5 pairs with q=40 and a=b=k (k=1..5); hold ready_i=0 for 4 cycles once valid_o rises. Expected:
   - ready_o=0 during the stall.
   - c_o is held at 2.
   - Outputs then resume as 2,4,6,8,10 in order, with no loss or duplication.
4. Range error: q=40, (a=40,b=1) gives err_o=1 and c_o=1. The following (a=39,b=0) gives err_o=0 and c_o=39.
5. Reset mid-flight: accept 2 pairs, assert rst_i for 1 cycle before either emerges. Expected:
   - valid_o=0, c_o=0, err_o=0 on the cycle after reset.
   - The stale results never appear.
   - The next accepted pair emerges 2 cycles later.
6. Per-transaction modulus: (a=20,b=13,q=40) then (a=20,b=13,q=30) back-to-back gives 33 then 3.
